// File: rtl/prog_counter_if.sv
// Control and status bundle for prog_counter: the slave side receives the control inputs
// and drives the counter status outputs.
interface prog_counter_if #(
  parameter int unsigned BW     = 8,
  parameter int unsigned PRE_BW = 4
);
  logic              clr_i;
  logic              en_i;
  logic              up_i;
  logic              sat_i;
  logic              load_i;
  logic [BW-1:0]     load_val_i;
  logic [BW-1:0]     max_val_i;
  logic [PRE_BW-1:0] prescale_i;
  logic [BW-1:0]     counter_val_o;
  logic              tc_o;
  logic              ovf_o;

  modport master (
    output clr_i, en_i, up_i, sat_i, load_i, load_val_i, max_val_i, prescale_i,
    input  counter_val_o, tc_o, ovf_o
  );

  modport slave (
    input  clr_i, en_i, up_i, sat_i, load_i, load_val_i, max_val_i, prescale_i,
    output counter_val_o, tc_o, ovf_o
  );
endinterface

// File: rtl/prog_counter.sv
// Up/down counter with programmable terminal value, prescaler, load/clear, wrap or
// saturate mode, a one-cycle terminal-count pulse and a sticky overflow flag.
module prog_counter #(
  parameter int unsigned BW     = 8,
  parameter int unsigned PRE_BW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  prog_counter_if.slave bus
);

  localparam logic [BW-1:0]     CntOne = BW'(1);
  localparam logic [PRE_BW-1:0] PreOne = PRE_BW'(1);

  logic [BW-1:0]     cnt_q, cnt_d;
  logic [PRE_BW-1:0] pre_q, pre_d;
  logic              tc_q, tc_d;
  logic              ovf_q, ovf_d;
  logic              tick;

  assign tick = bus.en_i && (pre_q == bus.prescale_i);

  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (bus.clr_i) begin
      cnt_d = '0;
      pre_d = '0;
      ovf_d = 1'b0;
    end else if (bus.load_i) begin
      cnt_d = bus.load_val_i;
      pre_d = '0;
    end else begin
      // A prescale value lowered below pre_q lets pre_q roll over until it matches.
      if (tick) begin
        pre_d = '0;
      end else if (bus.en_i) begin
        pre_d = pre_q + PreOne;
      end
      if (tick) begin
        if (bus.up_i) begin
          if (cnt_q < bus.max_val_i) begin
            cnt_d = cnt_q + CntOne;
          end else if (bus.sat_i) begin
            cnt_d = bus.max_val_i;
            tc_d  = 1'b1;
          end else begin
            cnt_d = '0;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
          end else if (bus.sat_i) begin
            tc_d = 1'b1;
          end else begin
            cnt_d = bus.max_val_i;
            tc_d  = 1'b1;
            ovf_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      pre_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.counter_val_o = cnt_q;
  assign bus.tc_o          = tc_q;
  assign bus.ovf_o         = ovf_q;

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised successor to the free-running counter: an up/down counter with programmable terminal value, prescaler, synchronous load/clear, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Serves as the general-purpose timebase/event counter for TinyTapeout user designs.
- All state is in one clock domain.

Parameters:
- BW, 8, counter width in bits (>=2).
- PRE_BW, 4, prescaler width in bits (>=1).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- clr_i  input  1  synchronous clear: counter, prescaler and ovf_o go to 0.
- en_i  input  1  count enable; gates the prescaler.
- up_i  input  1  direction: 1 = up, 0 = down.
- sat_i  input  1  mode: 1 = saturate at the terminal value, 0 = wrap.
- load_i  input  1  synchronous load of load_val_i.
- load_val_i  input  BW  load value.
- max_val_i  input  BW  terminal value for counting up and wrap target for counting down.
- prescale_i  input  PRE_BW  a count step occurs every prescale_i+1 enabled cycles.
- counter_val_o  output  BW  current count, registered.
- tc_o  output  1  terminal-count pulse, registered, one cycle wide.
- ovf_o  output  1  sticky wrap flag, registered.

Behaviour:
- Reset (rst_ni=0, asynchronous): counter_val_o=0, prescaler=0, tc_o=0, ovf_o=0. Release is synchronous to the next edge.
- Priority per edge: clr_i > load_i > count step > hold.
- clr_i=1: counter=0, prescaler=0, ovf_o=0, tc_o=0.
- load_i=1 (clr_i=0): counter=load_val_i, prescaler=0, tc_o=0, ovf_o unchanged. The load value is not clamped to max_val_i.
- Prescaler:
  - tick = en_i && (pre_cnt == prescale_i).
  - On tick, pre_cnt goes to 0. Otherwise, when en_i=1, pre_cnt increments. When en_i=0, pre_cnt holds.
  - prescale_i=0 gives a tick on every enabled cycle.
  - If prescale_i changes so that pre_cnt > prescale_i, pre_cnt increments modulo 2^PRE_BW until it matches.
- Count step on tick, up (up_i=1):
  - counter < max_val_i: counter+1, tc_o=0.
  - counter >= max_val_i, wrap mode: counter=0, tc_o=1, ovf_o=1.
  - counter >= max_val_i, saturate mode: counter=max_val_i, tc_o=1, ovf_o unchanged.
- Count step on tick, down (up_i=0):
  - counter > 0: counter-1, tc_o=0. This also applies when counter is above max_val_i.
  - counter == 0, wrap mode: counter=max_val_i, tc_o=1, ovf_o=1.
  - counter == 0, saturate mode: counter=0, tc_o=1.
- tc_o:
  - High only in the cycle immediately after a terminal tick, aligned with the updated counter_val_o. Otherwise it is 0.
  - In saturate mode, tc_o pulses on every tick while held at the terminal value.
- Latency: one cycle from a tick, load or clr edge to counter_val_o, tc_o and ovf_o.
- max_val_i=0: up wraps or sticks at 0 with tc_o on every tick. Down behaves the same.
- max_val_i = 2^BW-1: up wrap is the natural modulo-2^BW rollover.
- Direction or mode changes take effect on the next tick. No internal state depends on them.
- Reset mid-count clears everything immediately, independent of clk_i.
- All arithmetic is BW-bit with no carry-out. Comparisons are unsigned.

Test Plan:
- Reset/free-run: rst_ni pulse low mid-cycle, then en_i=1, up_i=1, prescale_i=0, max_val_i=255 -> outputs 0 asynchronously. After release: 0,1,2,…,255,0. tc_o high for exactly one cycle with counter=0. ovf_o=1 thereafter.
- Modulo-5 up wrap: max_val_i=4, sat_i=0 -> sequence 0,1,2,3,4,0,1… with tc_o high each cycle count=0 after 4. Then clr_i=1 -> counter=0, ovf_o=0.
- Saturate down: load_i with load_val_i=2, up_i=0, sat_i=1 -> 2,1,0,0,0. tc_o high on each cycle at 0 after the first arrival. ovf_o stays 0.
- Prescaler: prescale_i=3, en_i=1, up -> count increments every 4th cycle. en_i=0 for 2 cycles mid-period -> period stretches to 6 cycles, with no lost or extra tick.
- Priority: clr_i=1, load_i=1 and tick in the same cycle -> counter=0. load_i=1 with tick, load_val_i=9 -> counter=9 and tc_o=0.
- Above-max: max_val_i=4, load 10, up, wrap -> next tick gives counter=0, tc_o=1. Same load counting down -> 9,8,….
